// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: common fetch (T0-T2) then an opcode-specific execute sequence.
// Define CONTROL_SEQ_MULDIV_EN to add the mul/div execute sequence; otherwise both decode as nop.
module control_sequencer #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        ZHighout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        MDRout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        ZHIin,
    output logic        ZLOin,
    output logic        CONin,
    output logic        OutPortin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  operation,
    output logic        Run,
    output logic [4:0]  dbg_state
);

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110, OP_OUT  = 5'b10111, OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001, OP_HALT = 5'b11011;

    typedef enum logic [4:0] {
        S_T0, S_T1, S_T2,
        S_ALU_T3, S_ALU_T4R, S_ALU_T4I, S_ALU_T5,
        S_NEG_T3, S_NEG_T4,
        S_ADR_T3, S_ADR_T4, S_ADR_T5,
        S_LD_T6, S_LD_T7, S_ST_T6, S_ST_T7,
        S_BR_T3, S_BR_T4, S_BR_T5, S_BR_T6,
        S_JR_T3, S_IN_T3, S_OUT_T3, S_MFHI_T3, S_MFLO_T3,
        S_MD_T3, S_MD_T4, S_MD_T5, S_MD_T6,
        S_HALT
    } state_t;

    typedef struct packed {
        logic       pc_out, zlow_out, zhigh_out, hi_out, lo_out, inport_out, c_out, mdr_out;
        logic       pc_in, ir_in, mar_in, mdr_in, y_in, hi_in, lo_in, zhi_in, zlo_in, con_in, outport_in;
        logic       gra, grb, grc, r_in, r_out, ba_out;
        logic       inc_pc, read, write;
        logic [4:0] operation;
    } ctrl_t;

    state_t     state;
    state_t     next_state;
    state_t     last_next;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl_out;
    logic       run_q;
    logic [4:0] opcode;
    logic       is_imm;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign is_imm    = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign last_next = Stop ? S_HALT : S_T0;

    function automatic logic [4:0] imm_code(input logic [4:0] op);
        case (op)
            OP_ANDI: imm_code = OP_AND;
            OP_ORI:  imm_code = OP_OR;
            default: imm_code = OP_ADD;
        endcase
    endfunction

    always_comb begin
        next_state = S_T0;
        case (state)
            S_T0: next_state = S_T1;
            S_T1: next_state = S_T2;
            S_T2: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
                    OP_ADDI, OP_ANDI, OP_ORI:  next_state = S_ALU_T3;
                    OP_NEG, OP_NOT:            next_state = S_NEG_T3;
                    OP_LD, OP_LDI, OP_ST:      next_state = S_ADR_T3;
                    OP_BR:                     next_state = S_BR_T3;
                    OP_JR:                     next_state = S_JR_T3;
                    OP_IN:                     next_state = S_IN_T3;
                    OP_OUT:                    next_state = S_OUT_T3;
                    OP_MFHI:                   next_state = S_MFHI_T3;
                    OP_MFLO:                   next_state = S_MFLO_T3;
                    OP_HALT:                   next_state = S_HALT;
`ifdef CONTROL_SEQ_MULDIV_EN
                    OP_MUL, OP_DIV:            next_state = S_MD_T3;
`endif
                    default:                   next_state = last_next;
                endcase
            end
            S_ALU_T3:              next_state = is_imm ? S_ALU_T4I : S_ALU_T4R;
            S_ALU_T4R, S_ALU_T4I:  next_state = S_ALU_T5;
            S_NEG_T3:              next_state = S_NEG_T4;
            S_ADR_T3:              next_state = S_ADR_T4;
            // ldi finishes through the shared ALU write-back step
            S_ADR_T4:              next_state = (opcode == OP_LDI) ? S_ALU_T5 : S_ADR_T5;
            S_ADR_T5:              next_state = (opcode == OP_ST) ? S_ST_T6 : S_LD_T6;
            S_LD_T6:               next_state = S_LD_T7;
            S_ST_T6:               next_state = S_ST_T7;
            S_BR_T3:               next_state = S_BR_T4;
            S_BR_T4:               next_state = S_BR_T5;
            S_BR_T5:               next_state = S_BR_T6;
            S_MD_T3:               next_state = S_MD_T4;
            S_MD_T4:               next_state = S_MD_T5;
            S_MD_T5:               next_state = S_MD_T6;
            S_HALT:                next_state = S_HALT;
            S_ALU_T5, S_NEG_T4, S_LD_T7, S_ST_T7, S_BR_T6, S_JR_T3, S_IN_T3,
            S_OUT_T3, S_MFHI_T3, S_MFLO_T3, S_MD_T6:
                                   next_state = last_next;
            default:               next_state = S_T0;
        endcase
    end

    function automatic ctrl_t decode(input state_t s, input logic [4:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_T0:      begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.zlo_in = 1'b1; end
            S_T1:      begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
            S_T2:      begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            S_ALU_T3:  begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
            S_ALU_T4R: begin c.grc = 1'b1; c.r_out = 1'b1; c.operation = op; c.zlo_in = 1'b1; end
            S_ALU_T4I: begin c.c_out = 1'b1; c.operation = imm_code(op); c.zlo_in = 1'b1; end
            S_ALU_T5,
            S_NEG_T4:  begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            S_NEG_T3:  begin c.grb = 1'b1; c.r_out = 1'b1; c.operation = op; c.zlo_in = 1'b1; end
            S_ADR_T3:  begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
            S_ADR_T4:  begin c.c_out = 1'b1; c.operation = ADD_OP; c.zlo_in = 1'b1; end
            S_ADR_T5:  begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
            S_LD_T6:   begin c.read = 1'b1; c.mdr_in = 1'b1; end
            S_LD_T7:   begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            S_ST_T6:   begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
            S_ST_T7:   c.write = 1'b1;
            S_BR_T3:   begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
            S_BR_T4:   begin c.pc_out = 1'b1; c.y_in = 1'b1; end
            S_BR_T5:   begin c.c_out = 1'b1; c.operation = ADD_OP; c.zlo_in = 1'b1; end
            S_BR_T6:   c.zlow_out = 1'b1;
            S_JR_T3:   begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
            S_IN_T3:   begin c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            S_OUT_T3:  begin c.gra = 1'b1; c.r_out = 1'b1; c.outport_in = 1'b1; end
            S_MFHI_T3: begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            S_MFLO_T3: begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
`ifdef CONTROL_SEQ_MULDIV_EN
            S_MD_T3:   begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
            S_MD_T4:   begin
                c.grb = 1'b1; c.r_out = 1'b1; c.operation = op; c.zhi_in = 1'b1; c.zlo_in = 1'b1;
            end
            S_MD_T5:   begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
            S_MD_T6:   begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
`endif
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!clr) begin
            state  <= S_T0;
            ctrl_q <= decode(S_T0, opcode);
            run_q  <= 1'b1;
        end else begin
            state  <= next_state;
            ctrl_q <= decode(next_state, opcode);
            run_q  <= (next_state != S_HALT);
        end
    end

    // Holding clr low forces every control quiet, even though state already sits at T0.
    assign ctrl_out  = clr ? ctrl_q : '0;
    assign Run       = clr & run_q;
    assign dbg_state = state;

    assign PCout     = ctrl_out.pc_out;
    assign Zlowout   = ctrl_out.zlow_out;
    assign ZHighout  = ctrl_out.zhigh_out;
    assign HIout     = ctrl_out.hi_out;
    assign LOout     = ctrl_out.lo_out;
    assign InPortout = ctrl_out.inport_out;
    assign Cout      = ctrl_out.c_out;
    assign MDRout    = ctrl_out.mdr_out;
    assign PCin      = ctrl_out.pc_in | (clr & (state == S_BR_T6) & CON_FF);
    assign IRin      = ctrl_out.ir_in;
    assign MARin     = ctrl_out.mar_in;
    assign MDRin     = ctrl_out.mdr_in;
    assign Yin       = ctrl_out.y_in;
    assign HIin      = ctrl_out.hi_in;
    assign LOin      = ctrl_out.lo_in;
    assign ZHIin     = ctrl_out.zhi_in;
    assign ZLOin     = ctrl_out.zlo_in;
    assign CONin     = ctrl_out.con_in;
    assign OutPortin = ctrl_out.outport_in;
    assign Gra       = ctrl_out.gra;
    assign Grb       = ctrl_out.grb;
    assign Grc       = ctrl_out.grc;
    assign Rin       = ctrl_out.r_in;
    assign Rout      = ctrl_out.r_out;
    assign BAout     = ctrl_out.ba_out;
    assign IncPC     = ctrl_out.inc_pc;
    assign Read      = ctrl_out.read;
    assign Write     = ctrl_out.write;
    assign operation = ctrl_out.operation;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction step tables from the instruction set feed an
// expected-vector queue; a negedge monitor compares every cycle's full control word against it.
module tb_control_sequencer;

    localparam int W = 34;
    typedef logic [W-1:0] vec_t;

`ifdef CONTROL_SEQ_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    localparam vec_t PCOUT    = vec_t'(1) << 33;
    localparam vec_t ZLOWOUT  = vec_t'(1) << 32;
    localparam vec_t ZHIGHOUT = vec_t'(1) << 31;
    localparam vec_t HIOUT    = vec_t'(1) << 30;
    localparam vec_t LOOUT    = vec_t'(1) << 29;
    localparam vec_t INPORT   = vec_t'(1) << 28;
    localparam vec_t COUT     = vec_t'(1) << 27;
    localparam vec_t MDROUT   = vec_t'(1) << 26;
    localparam vec_t PCIN     = vec_t'(1) << 25;
    localparam vec_t IRIN     = vec_t'(1) << 24;
    localparam vec_t MARIN    = vec_t'(1) << 23;
    localparam vec_t MDRIN    = vec_t'(1) << 22;
    localparam vec_t YIN      = vec_t'(1) << 21;
    localparam vec_t HIIN     = vec_t'(1) << 20;
    localparam vec_t LOIN     = vec_t'(1) << 19;
    localparam vec_t ZHIIN    = vec_t'(1) << 18;
    localparam vec_t ZLOIN    = vec_t'(1) << 17;
    localparam vec_t CONIN    = vec_t'(1) << 16;
    localparam vec_t OUTPORT  = vec_t'(1) << 15;
    localparam vec_t GRA      = vec_t'(1) << 14;
    localparam vec_t GRB      = vec_t'(1) << 13;
    localparam vec_t GRC      = vec_t'(1) << 12;
    localparam vec_t RIN      = vec_t'(1) << 11;
    localparam vec_t ROUT     = vec_t'(1) << 10;
    localparam vec_t BAOUT    = vec_t'(1) << 9;
    localparam vec_t INCPC    = vec_t'(1) << 8;
    localparam vec_t READ     = vec_t'(1) << 7;
    localparam vec_t WRITE    = vec_t'(1) << 6;
    localparam vec_t RUN      = vec_t'(1);

    logic clk, clr, CON_FF, Stop;
    logic [31:0] IR;
    logic PCout, Zlowout, ZHighout, HIout, LOout, InPortout, Cout, MDRout;
    logic PCin, IRin, MARin, MDRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write, Run;
    logic [4:0] operation;
    logic [4:0] dbg_state;

    vec_t  exp_q[$];
    string name_q[$];
    vec_t  steps[$];
    int    checks = 0;
    int    errors = 0;

    control_sequencer #(.ADD_OP(5'b00011)) dut (
        .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .HIout(HIout), .LOout(LOout),
        .InPortout(InPortout), .Cout(Cout), .MDRout(MDRout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .HIin(HIin),
        .LOin(LOin), .ZHIin(ZHIin), .ZLOin(ZLOin), .CONin(CONin), .OutPortin(OutPortin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .IncPC(IncPC), .Read(Read), .Write(Write), .operation(operation), .Run(Run),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t opf(input logic [4:0] code);
        return vec_t'(code) << 1;
    endfunction

    // Reference model: the control words of every step of one instruction, fetch included.
    task automatic build_steps(input logic [4:0] op, input logic con, output bit halts);
        steps.delete();
        halts = 1'b0;
        steps.push_back(PCOUT | MARIN | INCPC | ZLOIN);
        steps.push_back(ZLOWOUT | PCIN | READ | MDRIN);
        steps.push_back(MDROUT | IRIN);
        if (op >= 5'd3 && op <= 5'd11) begin
            steps.push_back(GRB | ROUT | YIN);
            steps.push_back(GRC | ROUT | opf(op) | ZLOIN);
            steps.push_back(ZLOWOUT | GRA | RIN);
        end else if (op >= 5'd12 && op <= 5'd14) begin
            steps.push_back(GRB | ROUT | YIN);
            steps.push_back(COUT | opf(op == 5'd12 ? 5'd3 : (op == 5'd13 ? 5'd5 : 5'd6)) | ZLOIN);
            steps.push_back(ZLOWOUT | GRA | RIN);
        end else if (op == 5'd17 || op == 5'd18) begin
            steps.push_back(GRB | ROUT | opf(op) | ZLOIN);
            steps.push_back(ZLOWOUT | GRA | RIN);
        end else if (op <= 5'd2) begin
            steps.push_back(GRB | BAOUT | YIN);
            steps.push_back(COUT | opf(5'd3) | ZLOIN);
            if (op == 5'd1) begin
                steps.push_back(ZLOWOUT | GRA | RIN);
            end else begin
                steps.push_back(ZLOWOUT | MARIN);
                if (op == 5'd0) begin
                    steps.push_back(READ | MDRIN);
                    steps.push_back(MDROUT | GRA | RIN);
                end else begin
                    steps.push_back(GRA | ROUT | MDRIN);
                    steps.push_back(WRITE);
                end
            end
        end else if (op == 5'd19) begin
            steps.push_back(GRA | ROUT | CONIN);
            steps.push_back(PCOUT | YIN);
            steps.push_back(COUT | opf(5'd3) | ZLOIN);
            steps.push_back(ZLOWOUT | (con ? PCIN : vec_t'(0)));
        end else if (op == 5'd20) begin
            steps.push_back(GRA | ROUT | PCIN);
        end else if (op == 5'd22) begin
            steps.push_back(INPORT | GRA | RIN);
        end else if (op == 5'd23) begin
            steps.push_back(GRA | ROUT | OUTPORT);
        end else if (op == 5'd24) begin
            steps.push_back(HIOUT | GRA | RIN);
        end else if (op == 5'd25) begin
            steps.push_back(LOOUT | GRA | RIN);
        end else if (op == 5'd27) begin
            halts = 1'b1;
        end else if ((op == 5'd15 || op == 5'd16) && MULDIV) begin
            steps.push_back(GRA | ROUT | YIN);
            steps.push_back(GRB | ROUT | opf(op) | ZHIIN | ZLOIN);
            steps.push_back(ZLOWOUT | LOIN);
            steps.push_back(ZHIGHOUT | HIIN);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input vec_t v, input string name);
        exp_q.push_back(v);
        name_q.push_back(name);
    endtask

    task automatic do_reset(input int k);
        for (int i = 0; i < k; i++) begin
            clr    = 1'b0;
            IR     = $urandom;
            CON_FF = 1'($urandom_range(0, 1));
            Stop   = 1'($urandom_range(0, 1));
            expect_cycle('0, "reset");
            tick();
        end
    endtask

    task automatic run_instr(input logic [31:0] ir, input logic con, input bit stop_last,
                             input int abort_at, input string name);
        bit halts;
        int n;
        build_steps(ir[31:27], con, halts);
        n = steps.size();
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                do_reset(1 + $urandom_range(0, 1));
                return;
            end
            clr    = 1'b1;
            IR     = ir;
            CON_FF = con;
            Stop   = (i == n - 1) ? stop_last : 1'($urandom_range(0, 1));
            expect_cycle(steps[i] | RUN, $sformatf("%s op%0d T%0d", name, ir[31:27], i));
            tick();
        end
        if (halts || stop_last) begin
            for (int i = 0; i < 3; i++) begin
                Stop = 1'($urandom_range(0, 1));
                IR   = $urandom;
                expect_cycle('0, $sformatf("%s halted", name));
                tick();
            end
            do_reset(1 + $urandom_range(0, 2));
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        vec_t  act;
        vec_t  exp_v;
        string nm;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act = {PCout, Zlowout, ZHighout, HIout, LOout, InPortout, Cout, MDRout,
                   PCin, IRin, MARin, MDRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin,
                   Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write, operation, Run};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, act, exp_v);
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [31:0] ir;
        clr = 1'b0; IR = '0; CON_FF = 1'b0; Stop = 1'b0;
        tick();
        do_reset(3);
        run_instr(32'h18918000, 1'b0, 1'b0, -1, "add");
        run_instr(32'h00800010, 1'b1, 1'b0, -1, "ld");
        run_instr(32'h10880004, 1'b0, 1'b0, -1, "st");
        run_instr(32'h08800025, 1'b0, 1'b0, -1, "ldi");
        run_instr(32'h98800008, 1'b1, 1'b0, -1, "br_taken");
        run_instr(32'h98800008, 1'b0, 1'b0, -1, "br_not");
        run_instr(32'h68900003, 1'b0, 1'b0, -1, "andi");
        run_instr(32'h88900000, 1'b1, 1'b0, -1, "neg");
        run_instr(32'hA0800000, 1'b1, 1'b0, -1, "jr");
        run_instr(32'hD0000000, 1'b0, 1'b0, -1, "nop");
        run_instr(32'h80880000, 1'b0, 1'b0, -1, "mul");
        run_instr(32'h78880000, 1'b0, 1'b0, -1, "div");
        run_instr(32'h18918000, 1'b0, 1'b1, -1, "add_stop");
        run_instr(32'hD0000000, 1'b0, 1'b1, -1, "nop_stop");
        run_instr(32'hD8000000, 1'b0, 1'b0, -1, "halt");
        run_instr(32'h10880004, 1'b0, 1'b0, 6, "st_abort");
        run_instr(32'h18918000, 1'b0, 1'b0, -1, "after_abort");
        repeat (300) begin
            ir = $urandom;
            run_instr(ir, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1, "rand");
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
